dp_pool_window: RTL

- Upstream neighbour of the max-pooling stage in the dp accelerator datapath.
- Accepts a row-major matrix stream, one element per beat.
- Buffers K-1 rows in line buffers and emits each non-overlapping KxK pooling window (stride K) as K*K consecutive element beats.
- The pooling stage reduces each group of K*K beats to one result.

---
 rtl/dp_pool_window.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dp_pool_window.sv
// -----------------------------------------------------------------------------
// dp_pool_window
// Reorders a row-major matrix stream into non-overlapping KxK pooling windows
// (stride K) for the downstream max-pooling stage. K-1 rows of each band are
// kept in line buffers; the last band row is collected K elements at a time in
// a tail register. Each completed window is emitted as K*K beats in
// window-row-major order. Upstream is stalled while a window is emitted.
//
// Optional feature (compile-time macro DP_POOL_WINDOW_PAD_EN):
//   defined   : a column remainder (cols%K != 0) forms one extra window per
//               band, with the missing positions emitted as zero.
//   undefined : column and row remainders are consumed and discarded.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   start_i      frame start pulse (honoured in IDLE only)
//   cols_i       matrix width, sampled on start
//   rows_i       matrix height, sampled on start
//   busy_o       high from accepted start until the frame completes
//   done_o       one-cycle pulse at frame completion
//   mat_valid_i  input element stream: valid
//   mat_data_i   input element stream: data
//   mat_ready_o  input element stream: ready
//   win_valid_o  window beat stream: valid
//   win_data_o   window beat stream: data
//   win_strb_o   window beat stream: byte strobes (all ones)
//   win_ready_i  window beat stream: ready
// -----------------------------------------------------------------------------
module dp_pool_window #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned K         = 3,
    parameter int unsigned MAX_COLS  = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [$clog2(MAX_COLS+1)-1:0] cols_i,
    input  logic [15:0]                   rows_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          mat_valid_i,
    input  logic [WORD_SIZE-1:0]          mat_data_i,
    output logic                          mat_ready_o,
    output logic                          win_valid_o,
    output logic [WORD_SIZE-1:0]          win_data_o,
    output logic [(WORD_SIZE+7)/8-1:0]    win_strb_o,
    input  logic                          win_ready_i
);

    localparam int unsigned CW       = $clog2(MAX_COLS + 1);
    localparam int unsigned KW       = $clog2(K);
    localparam int unsigned LB_DEPTH = (K - 1) * MAX_COLS;
    localparam int unsigned AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

`ifdef DP_POOL_WINDOW_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_GATHER = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    state_e               state_q;
    state_e               post_q;      // where EMIT returns to
    logic [CW-1:0]        cols_q;
    logic [15:0]          rows_q;
    logic [CW-1:0]        full_cols_q; // (cols/K)*K: first column of the remainder
    logic [31:0]          total_q;
    logic [31:0]          cnt_q;       // elements consumed in this frame
    logic [15:0]          row_q;
    logic [CW-1:0]        col_q;
    logic [KW-1:0]        kc_q;        // col % K inside the gather row
    logic [KW-1:0]        brow_q;      // line-buffer row being filled
    logic [CW-1:0]        base_q;      // first column of the window being emitted
    logic [KW-1:0]        br_q;        // beat row within the window
    logic [KW-1:0]        bc_q;        // beat column within the window
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;
    logic                 valid_q;
    logic [WORD_SIZE-1:0] data_q;

    logic [WORD_SIZE-1:0] lb_q   [LB_DEPTH];
    logic [WORD_SIZE-1:0] tail_q [K];

    logic                 in_hs_s;
    logic                 out_hs_s;
    logic                 row_end_s;
    logic                 emit_s;
    logic                 band_left_s;
    logic                 last_beat_s;
    logic                 small_s;
    logic [CW-1:0]        full_cols_s;
    logic [31:0]          total_s;
    state_e               post_s;
    logic [KW-1:0]        sel_r_s;
    logic [KW-1:0]        sel_c_s;
    logic [CW-1:0]        sel_base_s;
    logic [31:0]          rd_idx_s;
    logic [WORD_SIZE-1:0] rd_val_s;

    assign in_hs_s     = mat_valid_i & ready_q;
    assign out_hs_s    = valid_q & win_ready_i;
    assign row_end_s   = (col_q == (cols_q - CW'(1)));
    // A full window completes on its last column; a padded one on the row's last column.
    assign emit_s      = ((kc_q == KW'(K - 1)) && (col_q < full_cols_q)) ||
                         (PAD_EN && row_end_s && (col_q >= full_cols_q));
    // After the current row, at least K rows must remain for another band.
    assign band_left_s = ((17'(row_q) + 17'(K) + 17'd1) <= 17'(rows_q));
    assign last_beat_s = (br_q == KW'(K - 1)) && (bc_q == KW'(K - 1));
    assign small_s     = (32'(cols_i) < K) || (32'(rows_i) < K);
    assign full_cols_s = CW'((32'(cols_i) / K) * K);
    assign total_s     = 32'(rows_i) * 32'(cols_i);

    // Next state after the gather row ends: another band or drain the rest.
    always_comb begin
        if (band_left_s) begin
            post_s = ST_FILL;
        end else begin
            post_s = ST_DRAIN;
        end
    end

    // Window beat read mux: beat 0 of a new window while gathering, else the next beat.
    always_comb begin
        sel_r_s    = '0;
        sel_c_s    = '0;
        sel_base_s = col_q - CW'(kc_q);
        if (state_q == ST_EMIT) begin
            sel_base_s = base_q;
            if (bc_q == KW'(K - 1)) begin
                sel_r_s = br_q + KW'(1);
                sel_c_s = '0;
            end else begin
                sel_r_s = br_q;
                sel_c_s = bc_q + KW'(1);
            end
        end else begin
            sel_base_s = col_q - CW'(kc_q);
        end
        rd_idx_s = 32'(sel_base_s) + 32'(sel_c_s);
        // Positions past the matrix edge (padded window) read as zero.
        if (rd_idx_s >= 32'(cols_q)) begin
            rd_val_s = '0;
        end else if (sel_r_s == KW'(K - 1)) begin
            rd_val_s = tail_q[sel_c_s];
        end else if (rd_idx_s < MAX_COLS) begin
            rd_val_s = lb_q[AW'(32'(sel_r_s) * MAX_COLS + rd_idx_s)];
        end else begin
            rd_val_s = '0;
        end
    end

    // Line-buffer write during the first K-1 rows of a band (no reset needed).
    always_ff @(posedge clk_i) begin
        if ((state_q == ST_FILL) && in_hs_s) begin
            lb_q[AW'(32'(brow_q) * MAX_COLS + 32'(col_q))] <= mat_data_i;
        end
    end

    // Tail register write during the last row of a band (no reset needed).
    always_ff @(posedge clk_i) begin
        if ((state_q == ST_GATHER) && in_hs_s) begin
            tail_q[kc_q] <= mat_data_i;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            post_q      <= ST_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            full_cols_q <= '0;
            total_q     <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            kc_q        <= '0;
            brow_q      <= '0;
            base_q      <= '0;
            br_q        <= '0;
            bc_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            if (in_hs_s) begin
                cnt_q <= cnt_q + 32'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        cols_q      <= cols_i;
                        rows_q      <= rows_i;
                        full_cols_q <= full_cols_s;
                        total_q     <= total_s;
                        cnt_q       <= '0;
                        row_q       <= '0;
                        col_q       <= '0;
                        kc_q        <= '0;
                        brow_q      <= '0;
                        busy_q      <= 1'b1;
                        if (small_s) begin
                            state_q <= ST_DRAIN;
                            ready_q <= (total_s != 32'd0);
                        end else begin
                            state_q <= ST_FILL;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_hs_s) begin
                        if (row_end_s) begin
                            col_q <= '0;
                            row_q <= row_q + 16'd1;
                            if (brow_q == KW'(K - 2)) begin
                                state_q <= ST_GATHER;
                                kc_q    <= '0;
                            end else begin
                                brow_q <= brow_q + KW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                ST_GATHER: begin
                    if (in_hs_s) begin
                        if (row_end_s) begin
                            col_q  <= '0;
                            kc_q   <= '0;
                            row_q  <= row_q + 16'd1;
                            brow_q <= '0;
                        end else begin
                            col_q <= col_q + CW'(1);
                            if (kc_q == KW'(K - 1)) begin
                                kc_q <= '0;
                            end else begin
                                kc_q <= kc_q + KW'(1);
                            end
                        end
                        if (emit_s) begin
                            state_q <= ST_EMIT;
                            post_q  <= row_end_s ? post_s : ST_GATHER;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            data_q  <= rd_val_s;
                            base_q  <= col_q - CW'(kc_q);
                            br_q    <= '0;
                            bc_q    <= '0;
                        end else if (row_end_s) begin
                            state_q <= post_s;
                            if (post_s == ST_FILL) begin
                                ready_q <= 1'b1;
                            end else begin
                                ready_q <= ((cnt_q + 32'd1) != total_q);
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    // Beat index and data move only on a downstream handshake.
                    if (out_hs_s) begin
                        if (last_beat_s) begin
                            valid_q <= 1'b0;
                            state_q <= post_q;
                            if (post_q == ST_DRAIN) begin
                                ready_q <= (cnt_q != total_q);
                            end else begin
                                ready_q <= 1'b1;
                            end
                        end else begin
                            br_q   <= sel_r_s;
                            bc_q   <= sel_c_s;
                            data_q <= rd_val_s;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Drop ready on the edge of the final handshake so nothing extra is taken.
                    if ((cnt_q + 32'(in_hs_s)) == total_q) begin
                        ready_q <= 1'b0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mat_ready_o = ready_q;
    assign win_valid_o = valid_q;
    assign win_data_o  = data_q;
    assign win_strb_o  = '1;

endmodule
